// File: rtl/serial_frame_receiver_if.sv
// Handshake/bus bundle between the serial transmitter, the frame receiver and its consumer.
interface serial_frame_receiver_if #(
  parameter int DataSize = 32
);
  logic                ClkTx;
  logic                DoutValid;
  logic                DataOut;
  logic                FrameAck;
  logic                ClearStatus;
  logic                FrameValid;
  logic [DataSize-1:0] FrameOut;
  logic [7:0]          OpA;
  logic [7:0]          OpB;
  logic [7:0]          AluResult;
  logic [3:0]          SelOut;
  logic [3:0]          FlagsOut;
  logic                FrameError;
  logic                Overrun;
  logic [7:0]          ErrorCount;
  logic                RxBusy;

  modport slave (
    input  ClkTx, DoutValid, DataOut, FrameAck, ClearStatus,
    output FrameValid, FrameOut, OpA, OpB, AluResult, SelOut, FlagsOut,
           FrameError, Overrun, ErrorCount, RxBusy
  );

  modport master (
    output ClkTx, DoutValid, DataOut, FrameAck, ClearStatus,
    input  FrameValid, FrameOut, OpA, OpB, AluResult, SelOut, FlagsOut,
           FrameError, Overrun, ErrorCount, RxBusy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// Rebuilds 32-bit calculator frames from the oversampled ClkTx/DoutValid/DataOut stream
// and holds each one behind a valid/ack handshake with abort, timeout and overrun status.
module serial_frame_receiver #(
  parameter int DataSize      = 32,
  parameter int SyncStages    = 2,
  parameter int TimeoutCycles = 1023
) (
  input logic                  Clk,
  input logic                  Reset,
  serial_frame_receiver_if.slave bus
);
  localparam int CW = $clog2(DataSize + 1);
  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic {IDLE, RECEIVE} state_t;

  state_t              r_state, w_next;
  logic [SyncStages-1:0] r_sclk, r_sval, r_sdat;
  logic                r_clk_prev;
  logic [CW-1:0]       r_cnt;
  logic [TW-1:0]       r_tmo;
  logic [DataSize-2:0] r_shift;
  logic [DataSize-1:0] r_frame;
  logic                r_valid, r_err, r_ovr;
  logic [7:0]          r_errcnt;

  logic w_clk_s, w_val_s, w_dat_s, w_bit;
  logic w_shift, w_done, w_abort, w_accept;

  // Identical chains keep the three inputs aligned to each other.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sclk     <= '0;
      r_sval     <= '0;
      r_sdat     <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_sclk     <= {r_sclk[SyncStages-2:0], bus.ClkTx};
      r_sval     <= {r_sval[SyncStages-2:0], bus.DoutValid};
      r_sdat     <= {r_sdat[SyncStages-2:0], bus.DataOut};
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_clk_s = r_sclk[SyncStages-1];
  assign w_val_s = r_sval[SyncStages-1];
  assign w_dat_s = r_sdat[SyncStages-1];
  assign w_bit   = w_clk_s & ~r_clk_prev;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_bit && w_val_s) begin
          w_shift = 1'b1;
          w_next  = RECEIVE;
        end
      end
      RECEIVE: begin
        if (!w_val_s || r_tmo == TW'(TimeoutCycles)) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (w_bit) begin
          w_shift = 1'b1;
          if (r_cnt == CW'(DataSize - 1)) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // An ack in the completion cycle frees the holding register for the new frame.
  assign w_accept = w_done & (~r_valid | bus.FrameAck);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_shift  <= '0;
      r_frame  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
      r_errcnt <= '0;
    end else begin
      if (w_abort || w_done) r_cnt <= '0;
      else if (w_shift)      r_cnt <= r_cnt + CW'(1);

      if (r_state != RECEIVE || w_bit) r_tmo <= '0;
      else                             r_tmo <= r_tmo + TW'(1);

      if (w_shift)  r_shift <= {r_shift[DataSize-3:0], w_dat_s};
      if (w_accept) r_frame <= {r_shift, w_dat_s};

      r_valid <= w_accept | (r_valid & ~bus.FrameAck);
      r_err   <= w_abort;

      if (w_done && !w_accept) r_ovr <= 1'b1;
      else if (bus.ClearStatus) r_ovr <= 1'b0;

      if (w_abort) r_errcnt <= (r_errcnt == 8'hFF) ? 8'hFF : r_errcnt + 8'd1;
      else if (bus.ClearStatus) r_errcnt <= '0;
    end
  end

  assign bus.FrameValid = r_valid;
  assign bus.FrameOut   = r_frame;
  assign bus.OpA        = r_frame[31:24];
  assign bus.OpB        = r_frame[23:16];
  assign bus.AluResult  = r_frame[15:8];
  assign bus.SelOut     = r_frame[7:4];
  assign bus.FlagsOut   = r_frame[3:0];
  assign bus.FrameError = r_err;
  assign bus.Overrun    = r_ovr;
  assign bus.ErrorCount = r_errcnt;
  assign bus.RxBusy     = (r_state == RECEIVE);
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed and randomized checks of serial_frame_receiver against a frame-level model.
module tb_serial_frame_receiver;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  serial_frame_receiver_if #(.DataSize(32)) bus ();

  serial_frame_receiver #(.DataSize(32), .SyncStages(2), .TimeoutCycles(1023)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0, passed = 0, fails = 0;
  int cnt, r, n, kind;
  logic [31:0] f;
  logic [31:0] m_frame;
  bit m_valid, m_ovr;
  int m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  // Transmitter bit: data and valid set up with ClkTx low, then ClkTx rises; ClkTx = Clk/4.
  task automatic send_bit(input bit b);
    bus.DataOut = b; bus.DoutValid = 1'b1; bus.ClkTx = 1'b0;
    cyc(2);
    bus.ClkTx = 1'b1;
    cyc(2);
  endtask

  task automatic send_frame(input logic [31:0] fr, input int nbits, input bit ack_last);
    for (int i = 0; i < nbits; i++) send_bit(fr[31-i]);
    if (ack_last) begin
      bus.FrameAck = 1'b1; cyc(1); bus.FrameAck = 1'b0;
    end
  endtask

  task automatic line_idle(input int k);
    bus.DoutValid = 1'b0; bus.ClkTx = 1'b0; bus.DataOut = 1'b0;
    cyc(k);
  endtask

  task automatic ack();
    bus.FrameAck = 1'b1; cyc(1); bus.FrameAck = 1'b0;
  endtask

  task automatic clear();
    bus.ClearStatus = 1'b1; cyc(1); bus.ClearStatus = 1'b0;
  endtask

  task automatic err_pulses(input int k, output int c);
    c = 0;
    repeat (k) begin
      @(negedge Clk);
      if (bus.FrameError) c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ClkTx = 0; bus.DoutValid = 0; bus.DataOut = 0; bus.FrameAck = 0; bus.ClearStatus = 0;

    // reset state
    cyc(3); sample();
    check("rst_valid", 32'(bus.FrameValid), 0);
    check("rst_frame", bus.FrameOut, 0);
    check("rst_errcnt", 32'(bus.ErrorCount), 0);
    check("rst_busy", 32'(bus.RxBusy), 0);
    Reset = 1'b1;
    cyc(2);

    // basic frame, latency and fields
    send_frame(32'h12345678, 32, 1'b0);
    sample();
    check("lat_early_valid", 32'(bus.FrameValid), 0);
    check("lat_busy_last", 32'(bus.RxBusy), 1);
    cyc(1); sample();
    check("lat_valid", 32'(bus.FrameValid), 1);
    check("lat_busy_done", 32'(bus.RxBusy), 0);
    check("t1_opa", 32'(bus.OpA), 32'h12);
    check("t1_opb", 32'(bus.OpB), 32'h34);
    check("t1_alu", 32'(bus.AluResult), 32'h56);
    check("t1_sel", 32'(bus.SelOut), 32'h7);
    check("t1_flags", 32'(bus.FlagsOut), 32'h8);
    ack(); sample();
    check("t1_ack_clear", 32'(bus.FrameValid), 0);
    check("t1_hold", bus.FrameOut, 32'h12345678);
    line_idle(4);

    // DoutValid abort after 17 bits
    send_frame(32'hA5A5A5A5, 17, 1'b0);
    bus.DoutValid = 1'b0; bus.ClkTx = 1'b0;
    err_pulses(12, cnt);
    check("t2_pulses", 32'(cnt), 1);
    check("t2_errcnt", 32'(bus.ErrorCount), 1);
    check("t2_valid", 32'(bus.FrameValid), 0);
    check("t2_busy", 32'(bus.RxBusy), 0);
    send_frame(32'h0000FF0F, 32, 1'b0);
    line_idle(4); sample();
    check("t2_next_valid", 32'(bus.FrameValid), 1);
    check("t2_next_frame", bus.FrameOut, 32'h0000FF0F);
    ack(); line_idle(2);

    // overrun with back-to-back frames
    send_frame(32'h11111111, 32, 1'b0);
    send_frame(32'h22222222, 32, 1'b0);
    line_idle(4); sample();
    check("t3_frame", bus.FrameOut, 32'h11111111);
    check("t3_ovr", 32'(bus.Overrun), 1);
    check("t3_valid", 32'(bus.FrameValid), 1);
    ack(); sample();
    check("t3_ack", 32'(bus.FrameValid), 0);
    check("t3_ovr_sticky", 32'(bus.Overrun), 1);
    clear(); sample();
    check("t3_ovr_clr", 32'(bus.Overrun), 0);
    check("t3_err_clr", 32'(bus.ErrorCount), 0);

    // ClkTx stall timeout
    send_frame(32'hFFFFFFFF, 5, 1'b0);
    cyc(900); sample();
    check("t4_busy_wait", 32'(bus.RxBusy), 1);
    check("t4_no_err_yet", 32'(bus.ErrorCount), 0);
    err_pulses(200, cnt);
    check("t4_pulses", 32'(cnt), 1);
    check("t4_busy", 32'(bus.RxBusy), 0);
    check("t4_errcnt", 32'(bus.ErrorCount), 1);
    line_idle(4);
    send_frame(32'hDEADBEEF, 32, 1'b0);
    line_idle(4); sample();
    check("t4_flags", 32'(bus.FlagsOut), 32'hF);
    check("t4_sel", 32'(bus.SelOut), 32'hE);
    check("t4_alu", 32'(bus.AluResult), 32'hBE);
    check("t4_opa", 32'(bus.OpA), 32'hDE);
    check("t4_opb", 32'(bus.OpB), 32'hAD);

    // asynchronous reset mid-frame
    send_frame(32'h13572468, 20, 1'b0);
    Reset = 1'b0;
    #2;
    check("t5_valid", 32'(bus.FrameValid), 0);
    check("t5_frame", bus.FrameOut, 0);
    check("t5_errcnt", 32'(bus.ErrorCount), 0);
    check("t5_busy", 32'(bus.RxBusy), 0);
    check("t5_ovr", 32'(bus.Overrun), 0);
    check("t5_ferr", 32'(bus.FrameError), 0);
    line_idle(3);
    Reset = 1'b1;
    err_pulses(5, cnt);
    check("t5_no_err", 32'(cnt), 0);
    send_frame(32'hCAFE0001, 32, 1'b0);
    line_idle(4); sample();
    check("t5_rx_valid", 32'(bus.FrameValid), 1);
    check("t5_rx_frame", bus.FrameOut, 32'hCAFE0001);

    // ErrorCount saturation, then ack coincident with completion
    for (int i = 0; i < 256; i++) begin
      send_frame($urandom, 3, 1'b0);
      line_idle(6);
    end
    sample();
    check("t6_sat", 32'(bus.ErrorCount), 255);
    check("t6_held", bus.FrameOut, 32'hCAFE0001);
    send_frame(32'h33333333, 32, 1'b1);
    line_idle(3); sample();
    check("t6_no_ovr", 32'(bus.Overrun), 0);
    check("t6_valid", 32'(bus.FrameValid), 1);
    check("t6_frame", bus.FrameOut, 32'h33333333);
    ack(); line_idle(2);

    // randomized frames against the frame-level model
    m_frame = 32'h33333333; m_valid = 0; m_ovr = 0; m_err = 255;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        clear(); m_ovr = 0; m_err = 0;
      end else if (r <= 2) begin
        ack(); m_valid = 0;
      end
      kind = $urandom_range(0, 3);
      f = $urandom;
      if (kind == 0) begin
        n = $urandom_range(1, 31);
        send_frame(f, n, 1'b0);
        line_idle(6);
        if (m_err < 255) m_err++;
      end else begin
        send_frame(f, 32, 1'b0);
        if (m_valid) m_ovr = 1;
        else begin m_frame = f; m_valid = 1; end
        if ($urandom_range(0, 1) == 1) line_idle(3);
        else cyc(3);
      end
      sample();
      check("rnd_valid", 32'(bus.FrameValid), 32'(m_valid));
      check("rnd_frame", bus.FrameOut, m_frame);
      check("rnd_opb", 32'(bus.OpB), 32'(m_frame[23:16]));
      check("rnd_ovr", 32'(bus.Overrun), 32'(m_ovr));
      check("rnd_errcnt", 32'(bus.ErrorCount), 32'(m_err));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Downstream stage of the binary calculator's serial transmitter. Consumes the DataOut / DoutValid / ClkTx bit stream and rebuilds each 32-bit frame.
- Splits each frame into its calculator fields (operand A, operand B, ALU result, selector, flags). Fields are packed MSB-first in that order.
- Presents the frame through a valid/ack handshake for the monitor or checker side. Flags framing errors, timeouts and overruns.

Parameters:
- DataSize, 32, frame width in bits; field outputs are defined for 32 only.
- SyncStages, 2, synchronizer depth applied to ClkTx, DoutValid and DataOut (minimum 2).
- TimeoutCycles, 1023, number of Clk cycles without a ClkTx rising edge mid-frame before the frame is aborted.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ClkTx  input  1  serial bit clock from the transmitter; sampled, not used as a clock.
- DoutValid  input  1  high while the transmitter drives frame bits.
- DataOut  input  1  serial data, MSB first.
- FrameAck  input  1  consumer accepts the held frame.
- ClearStatus  input  1  clears the sticky Overrun and ErrorCount.
- FrameValid  output  1  a held frame is available.
- FrameOut  output  32  held frame.
- OpA  output  8  FrameOut[31:24].
- OpB  output  8  FrameOut[23:16].
- AluResult  output  8  FrameOut[15:8].
- SelOut  output  4  FrameOut[7:4].
- FlagsOut  output  4  FrameOut[3:0].
- FrameError  output  1  one-cycle pulse on an aborted frame.
- Overrun  output  1  sticky; a completed frame was dropped.
- ErrorCount  output  8  saturating count of FrameError pulses.
- RxBusy  output  1  high while in state RECEIVE.

Behaviour:
- Reset (Reset=0, async):
  - All outputs and synchronizer flops go to 0; state = IDLE; bit counter = 0.
  - Reset mid-frame discards the partial frame with no FrameError.
- Synchronization:
  - ClkTx, DoutValid and DataOut pass through identical SyncStages-flop chains, so they stay mutually aligned.
  - A bit event occurs on the cycle where synced ClkTx = 1 and its previous synced value = 0.
- State IDLE:
  - A bit event with synced DoutValid = 1 enters RECEIVE.
  - The bit is shifted in as bit 31 and the bit counter becomes 1.
  - Bit events with DoutValid = 0 are ignored.
- State RECEIVE:
  - Each bit event with DoutValid = 1 shifts in the next bit (MSB first) and increments the counter.
  - Frame completion: when the counter reaches DataSize, return to IDLE on the same cycle the last bit is captured.
  - If FrameValid = 0 at completion:
    - FrameOut is loaded on the next cycle and FrameValid rises.
    - Latency is 1 Clk after the last bit event.
  - If FrameValid = 1 at completion: the new frame is dropped, Overrun is set, and the held frame is unchanged.
  - Abort: synced DoutValid falling to 0 while counter < DataSize.
    - Counts as an abort whether or not a bit event occurs in that cycle.
    - Response: FrameError pulse, ErrorCount increments (saturates at 255), return to IDLE, counter cleared.
  - Timeout: the timeout counter is reset on every bit event. When it reaches TimeoutCycles, the frame aborts with the same response as a DoutValid abort.
  - Back-to-back frames with DoutValid held high: the bit event after completion starts a new frame directly from IDLE, with no dead bit.
- Handshake:
  - FrameValid stays high until a cycle where FrameAck = 1; FrameValid clears on the next edge.
  - FrameAck while FrameValid = 0 has no effect.
  - If a frame completes in the same cycle FrameAck clears FrameValid, the new frame is accepted with no Overrun, and FrameValid stays high.
  - FrameOut holds its value while FrameValid = 0.
- Field outputs: purely combinational slices of FrameOut.
- ClearStatus: clears Overrun and ErrorCount on the next edge. If it coincides with a new FrameError or Overrun event, the new event wins.

Test Plan:
- Send frame 0x12345678, DoutValid high for 32 ClkTx periods (ClkTx = Clk/4) -> FrameValid rises 1 Clk after the last bit event; OpA=0x12, OpB=0x34, AluResult=0x56, SelOut=0x7, FlagsOut=0x8; ack -> FrameValid=0 the next cycle.
- Drop DoutValid after 17 bits of 0xA5A5A5A5 -> one FrameError pulse, ErrorCount=1, FrameValid stays 0; next full frame 0x0000FF0F is received correctly.
- Two frames 0x11111111 then 0x22222222 with no ack -> FrameOut=0x11111111 and Overrun=1; ack then ClearStatus -> Overrun=0.
- Stall ClkTx for 1023 cycles after 5 bits -> FrameError pulse and RxBusy=0; then frame 0xDEADBEEF -> FlagsOut=0xF, SelOut=0xE, AluResult=0xBE.
- Assert Reset=0 mid-frame at bit 20 -> all outputs 0 immediately; after release, frame 0xCAFE0001 is received intact.
- 256 aborted frames -> ErrorCount saturates at 255; FrameAck coincident with completion of 0x33333333 -> no Overrun, FrameOut=0x33333333.
